dphy_hs_data_tx: RTL and testbench
==================================

DPHY_HS_DATA_TX -- requirements
Module: dphy_hs_data_tx

Interface
REQ-001 SHALL have parameter LPX_CYCLES, default 4: LP-01 (HS-request) duration in byte clocks.
REQ-002 SHALL have parameter HS_PREPARE_CYCLES, default 3: LP-00 duration in byte clocks.
REQ-003 SHALL have parameter HS_ZERO_CYCLES, default 10: HS-zero duration in byte clocks.
REQ-004 SHALL have parameter HS_TRAIL_CYCLES, default 4: HS-trail duration in byte clocks.
REQ-005 SHALL have parameter HS_EXIT_CYCLES, default 6: post-burst LP-11 hold in byte clocks; all five parameters are legal from 1 to 255.
REQ-006 SHALL have port byte_clk_i, input, 1: the only clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port tx_valid_i, input, 1: payload byte valid.
REQ-009 SHALL have port tx_data_i, input, 8: payload byte; bit 0 goes first on the wire.
REQ-010 SHALL have port tx_last_i, input, 1: marks the final byte of a burst.
REQ-011 SHALL have port tx_ready_o, output, 1: a byte is accepted on a clock edge where tx_valid_i and tx_ready_o are both high.
REQ-012 SHALL have port hs_data_o, output, 8: parallel HS byte for the serializer; bit 0 is serialized first.
REQ-013 SHALL have port hs_en_o, output, 1: HS driver enable.
REQ-014 SHALL have ports lp_p_o and lp_n_o, outputs, 1 each: LP line levels.
REQ-015 SHALL have port busy_o, output, 1: high whenever the block is not in IDLE.
REQ-016 SHALL have port underflow_o, output, 1: one-cycle pulse flagging a burst cut short by missing data.

Function
REQ-017 SHALL implement states IDLE, HS_RQST, HS_PREP, HS_ZERO, SYNC, DATA, TRAIL, EXIT.
REQ-018 SHALL register every output; hs_en_o, lp_p_o and lp_n_o SHALL change on the same edge that enters the new state.
REQ-019 SHALL use one 8-bit down-counter for state timing:
  - loaded with (parameter - 1) on entry to a timed state;
  - the state exits on the edge where the counter equals 0;
  - so each timed state lasts exactly its parameter value in cycles.
REQ-020 SHALL drive LP levels (lp_p_o/lp_n_o) per state:
  - IDLE and EXIT: 1/1;
  - HS_RQST: 0/1;
  - all other states: 0/0.
REQ-021 SHALL drive hs_en_o high in HS_ZERO, SYNC, DATA and TRAIL only.
REQ-022 SHALL move from IDLE to HS_RQST on an edge where tx_valid_i is high; no byte is accepted in IDLE.
REQ-023 SHALL sequence the timed states HS_RQST (LPX_CYCLES), HS_PREP (HS_PREPARE_CYCLES) and HS_ZERO (HS_ZERO_CYCLES), then enter SYNC.
REQ-024 SHALL set hs_data_o to 0x00 throughout HS_ZERO and to 0xB8 for the single SYNC cycle.
REQ-025 SHALL drive tx_ready_o high in SYNC and DATA only, as a combinational decode of the state.
REQ-026 SHALL, on an edge in SYNC or DATA with tx_valid_i high, load hs_data_o with tx_data_i (one-cycle latency) and:
  - go to TRAIL if tx_last_i is high;
  - otherwise go to (or stay in) DATA.
REQ-027 SHALL treat tx_valid_i low on an edge in SYNC or DATA as underflow:
  - pulse underflow_o for one cycle;
  - enter TRAIL immediately.
REQ-028 SHALL drive hs_data_o throughout TRAIL with the trail byte:
  - 0xFF if bit 7 of the last transmitted byte was 0, else 0x00;
  - the last transmitted byte includes 0xB8 when underflow occurs in SYNC.
REQ-029 SHALL move from TRAIL to EXIT after HS_TRAIL_CYCLES, setting hs_data_o to 0x00.
REQ-030 SHALL stay in EXIT for HS_EXIT_CYCLES, then return to IDLE.
REQ-031 SHALL ignore tx_valid_i in TRAIL and EXIT; a pending next burst starts from IDLE on the first edge after EXIT.

Reset
REQ-032 SHALL, while rst_i is high and regardless of state, immediately force:
  - state IDLE;
  - lp_p_o=1, lp_n_o=1;
  - hs_en_o=0, hs_data_o=0x00;
  - tx_ready_o=0, busy_o=0, underflow_o=0;
  - counter 0.
REQ-033 SHALL abort any burst in progress on reset, with no trail and no underflow pulse.

Verification
REQ-034 SHALL pass reset: assert rst_i with state in any position -> outputs at REQ-032 values, held until rst_i is released.
REQ-035 SHALL pass the nominal burst (default parameters), bytes 0x11, 0x22, 0x33 with last on 0x33 and valid held -> on the wire:
  - 4 cycles LP 0/1, then 3 cycles LP 0/0;
  - hs_en_o=1 with 10 cycles of 0x00;
  - 0xB8, 0x11, 0x22, 0x33;
  - 4 cycles of 0xFF;
  - hs_en_o=0 with LP 1/1 for 6 cycles;
  - busy_o low afterwards.
REQ-036 SHALL pass underflow: drop tx_valid_i after 0x11, 0x22 -> underflow_o pulses one cycle, then 4 cycles of 0xFF trail (0x22 bit 7 is 0), then EXIT.
REQ-037 SHALL pass the high-bit trail: single byte 0x80 with last -> trail bytes are 0x00.
REQ-038 SHALL pass reset mid-burst: rst_i pulsed while in DATA -> same cycle lp_p_o/lp_n_o = 1/1 and hs_en_o=0; no trail.
REQ-039 SHALL pass back-to-back bursts: tx_valid_i held high after last -> tx_ready_o stays low through TRAIL and EXIT, and the next HS_RQST begins exactly 1 cycle after EXIT ends.

Source files
------------

// File: rtl/dphy_hs_data_tx.sv
// -----------------------------------------------------------------------------
// dphy_hs_data_tx
//
// Purpose:
//   MIPI D-PHY high-speed data lane transmit sequencer running in the byte
//   clock domain. Each burst walks through these phases:
//     LP-11 idle -> LP-01 HS-request -> LP-00 HS-prepare -> HS-zero
//     -> sync byte 0xB8 -> payload bytes -> HS-trail -> LP-11 exit hold.
//   The parallel byte is handed to an external serializer (bit 0 first).
//
// Ports:
//   byte_clk_i   in   1  byte clock; all logic runs on its rising edge
//   rst_i        in   1  asynchronous active-high reset
//   tx_valid_i   in   1  payload byte valid
//   tx_data_i    in   8  payload byte (bit 0 first on the wire)
//   tx_last_i    in   1  final byte of the burst
//   tx_ready_o   out  1  byte accepted when tx_valid_i && tx_ready_o
//   hs_data_o    out  8  parallel HS byte for the serializer
//   hs_en_o      out  1  HS driver enable
//   lp_p_o       out  1  LP level, P line
//   lp_n_o       out  1  LP level, N line
//   busy_o       out  1  high whenever the sequencer is not idle
//   underflow_o  out  1  one-cycle pulse: burst cut short by missing data
// -----------------------------------------------------------------------------
module dphy_hs_data_tx #(
    parameter int LPX_CYCLES        = 4,
    parameter int HS_PREPARE_CYCLES = 3,
    parameter int HS_ZERO_CYCLES    = 10,
    parameter int HS_TRAIL_CYCLES   = 4,
    parameter int HS_EXIT_CYCLES    = 6
) (
    input  logic       byte_clk_i,
    input  logic       rst_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    output logic       tx_ready_o,
    output logic [7:0] hs_data_o,
    output logic       hs_en_o,
    output logic       lp_p_o,
    output logic       lp_n_o,
    output logic       busy_o,
    output logic       underflow_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HS_RQST = 3'd1,
        HS_PREP = 3'd2,
        HS_ZERO = 3'd3,
        SYNC    = 3'd4,
        DATA    = 3'd5,
        TRAIL   = 3'd6,
        EXIT    = 3'd7
    } state_t;

    localparam logic [7:0] SYNC_BYTE  = 8'hB8;
    localparam logic [7:0] LPX_LOAD   = 8'(LPX_CYCLES - 1);
    localparam logic [7:0] PREP_LOAD  = 8'(HS_PREPARE_CYCLES - 1);
    localparam logic [7:0] ZERO_LOAD  = 8'(HS_ZERO_CYCLES - 1);
    localparam logic [7:0] TRAIL_LOAD = 8'(HS_TRAIL_CYCLES - 1);
    // When TRAIL is entered by accepting the last byte, its first cycle still
    // carries that payload byte, so one extra count keeps the trail byte on
    // the wire for the full HS_TRAIL_CYCLES.
    localparam logic [7:0] TRAIL_LOAD_LAST = 8'(HS_TRAIL_CYCLES);
    localparam logic [7:0] EXIT_LOAD  = 8'(HS_EXIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] hs_data_q, hs_data_d;
    logic [7:0] trail_q, trail_d;
    logic       hs_en_q, hs_en_d;
    logic       lp_p_q, lp_p_d;
    logic       lp_n_q, lp_n_d;
    logic       busy_q, busy_d;
    logic       underflow_q, underflow_d;

    logic       cnt_done;
    logic       data_phase;

    assign cnt_done   = (cnt_q == 8'd0);
    assign data_phase = (state_q == SYNC) || (state_q == DATA);

    // Trail byte is the complement of the last transmitted bit.
    function automatic logic [7:0] trail_of(input logic msb);
        return msb ? 8'h00 : 8'hFF;
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge byte_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            hs_data_q   <= 8'h00;
            trail_q     <= 8'h00;
            hs_en_q     <= 1'b0;
            lp_p_q      <= 1'b1;
            lp_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hs_data_q   <= hs_data_d;
            trail_q     <= trail_d;
            hs_en_q     <= hs_en_d;
            lp_p_q      <= lp_p_d;
            lp_n_q      <= lp_n_d;
            busy_q      <= busy_d;
            underflow_q <= underflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and timing counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_done ? 8'd0 : (cnt_q - 8'd1);
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (tx_valid_i) begin
                    state_d = HS_RQST;
                    cnt_d   = LPX_LOAD;
                end
            end
            HS_RQST: begin
                if (cnt_done) begin
                    state_d = HS_PREP;
                    cnt_d   = PREP_LOAD;
                end
            end
            HS_PREP: begin
                if (cnt_done) begin
                    state_d = HS_ZERO;
                    cnt_d   = ZERO_LOAD;
                end
            end
            HS_ZERO: begin
                if (cnt_done) begin
                    state_d = SYNC;
                    cnt_d   = 8'd0;
                end
            end
            SYNC, DATA: begin
                cnt_d = 8'd0;
                if (tx_valid_i && tx_last_i) begin
                    state_d = TRAIL;
                    cnt_d   = TRAIL_LOAD_LAST;
                end else if (tx_valid_i) begin
                    state_d = DATA;
                end else begin
                    // Data ran dry mid-burst: close the burst right away.
                    state_d = TRAIL;
                    cnt_d   = TRAIL_LOAD;
                end
            end
            TRAIL: begin
                if (cnt_done) begin
                    state_d = EXIT;
                    cnt_d   = EXIT_LOAD;
                end
            end
            EXIT: begin
                if (cnt_done) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: values for the state being entered, so the registered
    // outputs change on the same edge as the state.
    // ------------------------------------------------------------------
    always_comb begin
        lp_p_d      = 1'b1;
        lp_n_d      = 1'b1;
        hs_en_d     = 1'b0;
        hs_data_d   = 8'h00;
        underflow_d = 1'b0;
        busy_d      = (state_d != IDLE);
        trail_d     = trail_q;

        // Track the trail byte from whatever goes out last: the accepted
        // byte, or the byte already on the wire (0xB8 if SYNC underflows).
        if (data_phase) begin
            trail_d     = tx_valid_i ? trail_of(tx_data_i[7]) : trail_of(hs_data_q[7]);
            underflow_d = !tx_valid_i;
        end

        case (state_d)
            HS_RQST: begin
                lp_p_d = 1'b0;
            end
            HS_PREP: begin
                lp_p_d = 1'b0;
                lp_n_d = 1'b0;
            end
            HS_ZERO: begin
                lp_p_d  = 1'b0;
                lp_n_d  = 1'b0;
                hs_en_d = 1'b1;
            end
            SYNC: begin
                lp_p_d    = 1'b0;
                lp_n_d    = 1'b0;
                hs_en_d   = 1'b1;
                hs_data_d = SYNC_BYTE;
            end
            DATA: begin
                lp_p_d    = 1'b0;
                lp_n_d    = 1'b0;
                hs_en_d   = 1'b1;
                hs_data_d = tx_data_i;
            end
            TRAIL: begin
                lp_p_d  = 1'b0;
                lp_n_d  = 1'b0;
                hs_en_d = 1'b1;
                if (data_phase && tx_valid_i) begin
                    hs_data_d = tx_data_i;     // last payload byte
                end else if (data_phase) begin
                    hs_data_d = trail_d;       // underflow: trail immediately
                end else begin
                    hs_data_d = trail_q;
                end
            end
            default: begin
                // IDLE and EXIT: LP-11, HS driver off.
            end
        endcase
    end

    assign tx_ready_o  = data_phase;
    assign hs_data_o   = hs_data_q;
    assign hs_en_o     = hs_en_q;
    assign lp_p_o      = lp_p_q;
    assign lp_n_o      = lp_n_q;
    assign busy_o      = busy_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_dphy_hs_data_tx.sv
// -----------------------------------------------------------------------------
// tb_dphy_hs_data_tx
//
// Directed bursts with hand-computed per-cycle wire expectations. Stimulus
// pushes the expected cycle sequence into a scoreboard queue; a monitor pops
// one entry per falling clock edge and compares it with the DUT outputs.
// Packed view: {lp_p, lp_n, hs_en, busy, ready, underflow, hs_data[7:0]}.
// -----------------------------------------------------------------------------
module tb_dphy_hs_data_tx;

    localparam int L = 4;
    localparam int P = 3;
    localparam int Z = 10;
    localparam int T = 4;
    localparam int X = 6;

    logic       byte_clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic [7:0] hs_data;
    logic       hs_en;
    logic       lp_p;
    logic       lp_n;
    logic       busy;
    logic       underflow;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [13:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    always #5 byte_clk = ~byte_clk;

    dphy_hs_data_tx #(
        .LPX_CYCLES       (L),
        .HS_PREPARE_CYCLES(P),
        .HS_ZERO_CYCLES   (Z),
        .HS_TRAIL_CYCLES  (T),
        .HS_EXIT_CYCLES   (X)
    ) dut (
        .byte_clk_i (byte_clk),
        .rst_i      (rst),
        .tx_valid_i (tx_valid),
        .tx_data_i  (tx_data),
        .tx_last_i  (tx_last),
        .tx_ready_o (tx_ready),
        .hs_data_o  (hs_data),
        .hs_en_o    (hs_en),
        .lp_p_o     (lp_p),
        .lp_n_o     (lp_n),
        .busy_o     (busy),
        .underflow_o(underflow)
    );

    function automatic logic [13:0] pk(input bit lpp, input bit lpn, input bit en,
                                       input bit bsy, input bit rdy, input bit uf,
                                       input logic [7:0] d);
        return {lpp, lpn, en, bsy, rdy, uf, d};
    endfunction

    function automatic logic [13:0] actual();
        return {lp_p, lp_n, hs_en, busy, tx_ready, underflow, hs_data};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got lp/en/busy/rdy/uf=%b data=%h, expected lp/en/busy/rdy/uf=%b data=%h",
                     name, act[13:8], act[7:0], exp[13:8], exp[7:0]);
        end
    endtask

    task automatic push(input string tag, input logic [13:0] v);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            push($sformatf("%s_idle%0d", tag, i), pk(1, 1, 0, 0, 0, 0, 8'h00));
    endtask

    // Whole burst as seen on the wire, starting with the IDLE cycle in which
    // tx_valid is first presented. b holds byte i in bits [8i+7:8i].
    task automatic push_burst(input string tag, input logic [31:0] b, input int n,
                              input bit last, input logic [7:0] trail);
        bit is_last;
        push($sformatf("%s_start", tag), pk(1, 1, 0, 0, 0, 0, 8'h00));
        for (int i = 0; i < L; i++)
            push($sformatf("%s_rqst%0d", tag, i), pk(0, 1, 0, 1, 0, 0, 8'h00));
        for (int i = 0; i < P; i++)
            push($sformatf("%s_prep%0d", tag, i), pk(0, 0, 0, 1, 0, 0, 8'h00));
        for (int i = 0; i < Z; i++)
            push($sformatf("%s_zero%0d", tag, i), pk(0, 0, 1, 1, 0, 0, 8'h00));
        push($sformatf("%s_sync", tag), pk(0, 0, 1, 1, 1, 0, 8'hB8));
        for (int i = 0; i < n; i++) begin
            is_last = last && (i == n - 1);
            push($sformatf("%s_byte%0d", tag, i), pk(0, 0, 1, 1, !is_last, 0, b[8*i +: 8]));
        end
        for (int i = 0; i < T; i++)
            push($sformatf("%s_trail%0d", tag, i), pk(0, 0, 1, 1, 0, (!last && i == 0), trail));
        for (int i = 0; i < X; i++)
            push($sformatf("%s_exit%0d", tag, i), pk(1, 1, 0, 1, 0, 0, 8'h00));
    endtask

    // Offers n bytes with valid held; drops valid once they are taken unless
    // keep is set. n == 0 only raises valid for the IDLE edge.
    task automatic drive_burst(input logic [31:0] b, input int n, input bit last, input bit keep);
        int  idx = 0;
        int  cyc = 0;
        bit  acc;
        tx_valid = 1'b1;
        tx_data  = b[7:0];
        tx_last  = last && (n == 1);
        if (n == 0) begin
            @(posedge byte_clk); #1;
            tx_valid = 1'b0;
            return;
        end
        while (idx < n && cyc < 200) begin
            @(negedge byte_clk);
            acc = tx_ready;
            @(posedge byte_clk); #1;
            cyc++;
            if (acc) begin
                idx++;
                if (idx < n) begin
                    tx_data = b[8*idx +: 8];
                    tx_last = last && (idx == n - 1);
                end
            end
        end
        if (idx < n) begin
            n_vec++;
            n_err++;
            $display("FAIL drive_timeout: accepted %0d bytes, required %0d", idx, n);
        end
        if (!keep) begin
            tx_valid = 1'b0;
            tx_last  = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag);
        int cyc = 0;
        while (exp_q.size() > 0 && cyc < 500) begin
            @(posedge byte_clk); #1;
            cyc++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_drain: %0d expected cycles left, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        @(posedge byte_clk); #1;
    endtask

    // Monitor: one scoreboard entry per cycle while entries are pending.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge byte_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.tag, actual(), e.v);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cyc;
        logic [13:0] rst_vals;
        rst_vals = pk(1, 1, 0, 0, 0, 0, 8'h00);

        // Reset at power-up.
        repeat (3) @(posedge byte_clk);
        @(negedge byte_clk);
        check("reset_hold", actual(), rst_vals);
        @(posedge byte_clk); #1;
        rst = 1'b0;
        push_idle("post_reset", 2);
        wait_drain("post_reset");

        // Nominal burst 0x11 0x22 0x33, last on 0x33.
        push_burst("nom", 32'h00332211, 3, 1'b1, 8'hFF);
        push_idle("nom_after", 2);
        drive_burst(32'h00332211, 3, 1'b1, 1'b0);
        wait_drain("nom");

        // Underflow after 0x11 0x22.
        push_burst("ufl", 32'h00002211, 2, 1'b0, 8'hFF);
        push_idle("ufl_after", 2);
        drive_burst(32'h00002211, 2, 1'b0, 1'b0);
        wait_drain("ufl");

        // High-bit trail: single byte 0x80 with last.
        push_burst("hib", 32'h00000080, 1, 1'b1, 8'h00);
        push_idle("hib_after", 2);
        drive_burst(32'h00000080, 1, 1'b1, 1'b0);
        wait_drain("hib");

        // Underflow in SYNC: trail follows 0xB8 (bit 7 set) -> 0x00.
        push_burst("usync", 32'h0, 0, 1'b0, 8'h00);
        push_idle("usync_after", 2);
        drive_burst(32'h0, 0, 1'b0, 1'b0);
        wait_drain("usync");

        // Back-to-back: valid held after last; single IDLE cycle between.
        push_burst("b2b_a", 32'h00005544, 2, 1'b1, 8'hFF);
        push_burst("b2b_b", 32'h0000C366, 2, 1'b1, 8'h00);
        push_idle("b2b_after", 2);
        drive_burst(32'h00005544, 2, 1'b1, 1'b1);
        drive_burst(32'h0000C366, 2, 1'b1, 1'b0);
        wait_drain("b2b");

        // Reset mid-burst while in DATA.
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        tx_last  = 1'b0;
        cyc = 0;
        do begin
            @(negedge byte_clk);
            cyc++;
        end while (!(tx_ready && hs_data == 8'h11) && cyc < 60);
        n_vec++;
        if (!(tx_ready && hs_data == 8'h11)) begin
            n_err++;
            $display("FAIL rst_mid_reach: DATA not reached in %0d cycles, required within 60", cyc);
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_immediate", actual(), rst_vals);
        @(posedge byte_clk); #1;
        check("rst_mid_held", actual(), rst_vals);
        tx_valid = 1'b0;
        @(posedge byte_clk); #1;
        rst = 1'b0;
        push_idle("rst_mid_after", 8);
        wait_drain("rst_mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
